uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serial UART transmitter: one 8-bit word per frame at one of 8 baud rates from a 50 MHz clk.
//   Frame format: start(0), D0..D7 LSB first, even parity, stop(1) = 11 bits.
//   Sits between the host write interface and the TxD line; its partner is uart_receiver.
// PARAMETERS
//   CLK_HZ          50_000_000  system clock frequency (divisor table below assumes this value)
//   OVERSAMPLE      16          sample ticks per bit
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   reset        in   1  synchronous, active-low reset
//   Tx_DATA      in   8  word to send, sampled when a write is accepted
//   baud_select  in   3  rate code (see BEHAVIOUR)
//   Tx_WR        in   1  write request, level-sensitive
//   Tx_EN        in   1  transmitter enable
//   TxD          out  1  serial line, idles high
//   Tx_BUSY      out  1  high while a frame is in flight
// BEHAVIOUR
// - Reset (reset==0 at a clk edge): state IDLE, TxD=1, Tx_BUSY=0, baud counter=0, tick counter=0.
// - Baud divisor N (clk cycles per sample tick), by baud_select 000..111:
//   10417 (300), 2604 (1200), 651 (4800), 326 (9600), 163 (19200), 81 (38400), 54 (57600), 27 (115200).
// - Sample tick: the baud counter counts 0..N-1, pulses sample_en for 1 cycle at N-1, then wraps to 0.
//   If baud_select changes so that count >= N-1, the counter pulses and wraps on the next cycle.
// - Accept: in IDLE with Tx_EN=1 and Tx_WR=1, Tx_DATA is latched into a shift register and parity is
//   computed as ^Tx_DATA (even parity). Baud and tick counters clear. Next state is START.
//   Tx_BUSY=1 and TxD=0 from the following cycle (1-cycle latency).
// - States: IDLE -> START -> DATA (8 bits) -> PARITY -> STOP -> IDLE.
//   Each bit lasts exactly 16 sample ticks, i.e. 16*N clk cycles. A frame is 176*N cycles.
// - TxD is registered: IDLE=1, START=0, DATA=shift[0] (shift right per bit), PARITY=parity, STOP=1.
// - After the 16th tick of STOP, state returns to IDLE with Tx_BUSY=0 and TxD=1 on the same edge.
// - Tx_WR while busy is ignored, with no queueing. Tx_DATA changes mid-frame have no effect.
//   If Tx_WR is still high in IDLE, a new frame starts (back-to-back frames allowed).
// - Tx_EN=0 in any state: abort to IDLE on the next edge, TxD=1, Tx_BUSY=0, counters cleared.
// - baud_select changing mid-frame takes effect immediately. The frame is not aborted.
// - Reset mid-frame has the same effect as power-up reset. No partial frame resumes.
// STRUCTURE
// - Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), divisor lookup function
//   baud_divisor(logic[2:0]) -> logic[13:0], constant OVERSAMPLE=16, FRAME_BITS=11.
// - Sub-module baud_controller (clk, reset, baud_select, clear -> sample_en). It is shared with
//   uart_receiver. The transmitter holds the FSM, the 4-bit tick counter, the 3-bit bit index,
//   the shift register and the parity bit.
// TESTING
// 1 Reset held low 2 cycles with Tx_WR=1 -> TxD=1, Tx_BUSY=0. No frame starts until reset=1.
// 2 baud 111, Tx_DATA=8'hDD, Tx_WR pulse 540 cycles -> TxD bits 0,1,0,1,1,1,0,1,1,0(parity),1,
//   each 432 cycles. Tx_BUSY high for 4752 cycles.
// 3 baud 000, Tx_DATA=8'h01 -> parity bit 1, each bit 166672 cycles. Check start bit width.
// 4 Tx_WR re-asserted mid-frame with Tx_DATA=8'h55 -> ignored. The frame for the first word is unchanged.
// 5 Tx_EN dropped at data bit 3 -> next cycle TxD=1, Tx_BUSY=0. Re-enable with Tx_WR -> clean new frame.
// 6 Tx_WR held high across a frame end, baud 110 -> a second frame starts 1 cycle after Tx_BUSY falls;
//   bit width 864 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: FSM states,
// oversampling constants and the baud-rate divisor table (50 MHz clock).
package uart_pkg;

  parameter int CLK_HZ     = 50_000_000;
  parameter int OVERSAMPLE = 16;
  parameter int FRAME_BITS = 11;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per sample tick; each entry is CLK_HZ / (OVERSAMPLE * baud), rounded.
  function automatic logic [13:0] baud_divisor(input logic [2:0] sel);
    logic [13:0] n;
    case (sel)
      3'b000:  n = 14'd10417;
      3'b001:  n = 14'd2604;
      3'b010:  n = 14'd651;
      3'b011:  n = 14'd326;
      3'b100:  n = 14'd163;
      3'b101:  n = 14'd81;
      3'b110:  n = 14'd54;
      default: n = 14'd27;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// Sample-tick generator: pulses sample_en once every baud_divisor(baud_select) cycles.
module baud_controller
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       sample_en
);

  logic [13:0] count_reg;
  logic [13:0] last_count;

  assign last_count = baud_divisor(baud_select) - 14'd1;
  // >= rather than == so a switch to a faster rate never lets the counter run past its end.
  assign sample_en  = !clear && (count_reg >= last_count);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear || sample_en) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 14'd1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop; 16 sample ticks per bit.
module uart_transmitter
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  output logic       TxD,
  output logic       Tx_BUSY
);

  tx_state_t  state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       parity;
  logic       sample_en;
  logic       clear;
  logic       bit_done;

  // Holding the divider in clear while idle makes every frame start on a fresh tick period.
  assign clear    = (state == IDLE) || !Tx_EN;
  assign bit_done = sample_en && (tick_cnt == LAST_TICK);

  baud_controller u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .clear       (clear),
    .sample_en   (sample_en)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      TxD       <= 1'b1;
      Tx_BUSY   <= 1'b0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
    end else if (!Tx_EN) begin
      state    <= IDLE;
      TxD      <= 1'b1;
      Tx_BUSY  <= 1'b0;
      tick_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if (state != IDLE && sample_en) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      case (state)
        IDLE: begin
          if (Tx_WR) begin
            shift_reg <= Tx_DATA;
            parity    <= ^Tx_DATA;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            state     <= START;
            TxD       <= 1'b0;
            Tx_BUSY   <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state <= DATA;
            TxD   <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              state <= PARITY;
              TxD   <= parity;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= shift_reg >> 1;
              TxD       <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state <= STOP;
            TxD   <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            state   <= IDLE;
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of whole frames plus hand-written
// sequences for reset, abort, back-to-back frames and a mid-frame baud change.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] baud_select = 3'b111;
  logic       tx_wr = 1'b0;
  logic       tx_en = 1'b1;
  logic       txd;
  logic       tx_busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (tx_data),
    .baud_select (baud_select),
    .Tx_WR       (tx_wr),
    .Tx_EN       (tx_en),
    .TxD         (txd),
    .Tx_BUSY     (tx_busy)
  );

  // frame[0] = start bit, frame[8:1] = data LSB first, frame[9] = parity, frame[10] = stop
  typedef struct {
    logic [7:0]  data;
    logic [2:0]  baud;
    int          width;
    logic [10:0] frame;
    bit          poke;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic wait_txd(input logic level, input int budget, input string name);
    int found = 0;
    for (int i = 0; i < budget; i++) begin
      if (txd === level) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check(name, found, 1);
  endtask

  // Starts a frame and checks both edges of every bit plus Tx_BUSY; returns at
  // the negedge one cycle after the frame has ended.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [2:0] baud,
                           input int w, input logic [10:0] frame, input bit poke, input bit hold_wr);
    baud_select = baud;
    tx_data     = data;
    tx_wr       = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 11 * w; c++) begin
      if (c < 11 * w && ((c % w) == 0 || (c % w) == w - 1))
        check($sformatf("%s_bit%0d_at%0d", tag, c / w, c), txd, frame[c / w]);
      if (c == 0 || c == 11 * w - 1)
        check($sformatf("%s_busy_at%0d", tag, c), tx_busy, 1);
      if (c == 11 * w) begin
        check($sformatf("%s_busy_end", tag), tx_busy, 0);
        check($sformatf("%s_txd_end", tag), txd, 1);
      end
      if (!hold_wr && c == 539) tx_wr = 1'b0;
      if (poke && c == 3 * w) begin
        tx_data = 8'h55;
        tx_wr   = 1'b1;
      end
      if (poke && c == 5 * w) tx_wr = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{8'hDD, 3'b111, 432, 11'b1_0_11011101_0, 1'b0};
    vecs[1] = '{8'hDD, 3'b111, 432, 11'b1_0_11011101_0, 1'b1};
    vecs[2] = '{8'h80, 3'b111, 432, 11'b1_1_10000000_0, 1'b0};
    vecs[3] = '{8'h7F, 3'b110, 864, 11'b1_1_01111111_0, 1'b0};

    // Reset held low with a pending write: line stays idle.
    reset = 1'b0;
    tx_wr = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", tx_busy, 0);
    tx_wr = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_txd", txd, 1);
    check("post_rst_busy", tx_busy, 0);

    for (int v = 0; v < 4; v++)
      run_frame($sformatf("v%0d", v), vecs[v].data, vecs[v].baud, vecs[v].width,
                vecs[v].frame, vecs[v].poke, 1'b0);

    // Abort during data bit 3, then a clean frame after re-enable.
    baud_select = 3'b111;
    tx_data     = 8'hC3;
    tx_wr       = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (1828) @(negedge clk);
    check("abort_pre_txd", txd, 0);
    check("abort_pre_busy", tx_busy, 1);
    tx_en = 1'b0;
    @(negedge clk);
    check("abort_txd", txd, 1);
    check("abort_busy", tx_busy, 0);
    tx_wr = 1'b1;
    repeat (3) @(negedge clk);
    check("disabled_busy", tx_busy, 0);
    check("disabled_txd", txd, 1);
    tx_wr = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);
    run_frame("reen", 8'h3C, 3'b111, 432, 11'b1_0_00111100_0, 1'b0, 1'b0);

    // Write held across the frame end: second frame after a single idle cycle.
    run_frame("b2b", 8'h81, 3'b110, 864, 11'b1_0_10000001_0, 1'b0, 1'b1);
    check("b2b_second_busy", tx_busy, 1);
    check("b2b_second_start", txd, 0);
    repeat (863) @(negedge clk);
    check("b2b_second_start_last", txd, 0);
    @(negedge clk);
    check("b2b_second_d0", txd, 1);
    tx_wr = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    check("b2b_abort_busy", tx_busy, 0);
    tx_en = 1'b1;
    @(negedge clk);

    // Slowest rate: start bit still low 20000 cycles in, then speed up mid-frame.
    baud_select = 3'b000;
    tx_data     = 8'h01;
    tx_wr       = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    check("slow_start_first", txd, 0);
    repeat (19999) @(negedge clk);
    check("slow_start_late", txd, 0);
    check("slow_busy_late", tx_busy, 1);
    baud_select = 3'b111;
    wait_txd(1'b1, 2000, "slow_start_end");
    repeat (216) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      logic [9:0] exp_bits;
      exp_bits = 10'b11_0000000_1;
      check($sformatf("slow_bit%0d", k + 1), txd, exp_bits[k]);
      if (k < 9) repeat (432) @(negedge clk);
    end
    repeat (215) @(negedge clk);
    check("slow_busy_last", tx_busy, 1);
    @(negedge clk);
    check("slow_busy_end", tx_busy, 0);
    check("slow_txd_end", txd, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
